// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing word fetches with a fixed memory latency into a prefetch FIFO.
// Redirects flush the FIFO and restart fetching; reset has priority over redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_instr_i,
  output logic        out_valid_o,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  input  logic        out_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_e;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   pc_q    [FIFO_DEPTH];
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic          full, pop, cap, push;
  assign out_valid_o = occ_q != '0;
  assign out_pc_o    = out_valid_o ? pc_q[rd_q] : 32'h0;
  assign out_instr_o = out_valid_o ? instr_q[rd_q] : 32'h0;
  assign mem_addr_o  = addr_q;
  // a full FIFO still accepts a push when the head leaves on the same edge
  always_comb begin
    full    = occ_q == (AW+1)'(FIFO_DEPTH);
    pop     = out_valid_o && out_ready_i;
    cap     = state_q == HOLD || (state_q == WAIT && cnt_q == 4'd1);
    push    = cap && (!full || pop) && !redirect_valid_i;
    state_d = redirect_valid_i ? ISSUE : state_q == ISSUE ? WAIT : push ? ISSUE : cap ? HOLD : state_q;
    cnt_d   = state_q == ISSUE ? 4'(MEM_LATENCY) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    addr_d  = redirect_valid_i ? (redirect_pc_i & ~32'd3) : push ? addr_q + 32'd4 : addr_q;
    occ_d   = redirect_valid_i ? '0 : occ_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_d    = redirect_valid_i ? '0 : rd_q + AW'(pop);
    wr_d    = redirect_valid_i ? '0 : wr_q + AW'(push);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ISSUE;
      cnt_q   <= '0;
      addr_q  <= RESET_PC & ~32'd3;
      occ_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      occ_q   <= occ_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      pc_q[wr_q]    <= addr_q;
      instr_q[wr_q] <= mem_instr_i;
    end
  end
endmodule
